// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: load-use stall, branch flush and EX-busy hold control for the ID/EX stage,
// with saturating debug counters for stall and flush cycles.
module id_ex_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_IDEX_MemRead,
    input  logic [4:0]       In_IDEX_RegRT,
    input  logic [4:0]       In_IFID_RegRS,
    input  logic [4:0]       In_IFID_RegRT,
    input  logic             In_IFID_UsesRT,
    input  logic             In_BranchTaken,
    input  logic             In_ExBusy,
    output logic             Out_PCWrite,
    output logic             Out_IFIDWrite,
    output logic             Out_IDEXWrite,
    output logic             Out_IDEXBubble,
    output logic             Out_IFIDFlush,
    output logic [1:0]       Out_State,
    output logic [CNT_W-1:0] Out_StallCount,
    output logic [CNT_W-1:0] Out_FlushCount
);
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HOLD = 2'd2} state_t;
    state_t state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic lu, stall;
    assign lu = In_IDEX_MemRead && (In_IDEX_RegRT != 5'd0) &&
                ((In_IDEX_RegRT == In_IFID_RegRS) ||
                 (In_IFID_UsesRT && (In_IDEX_RegRT == In_IFID_RegRT)));
    // HOLD with ExBusy low decodes exactly like RUN, so only FLUSH needs its own branch
    always_comb begin
        Out_PCWrite    = 1'b1;
        Out_IFIDWrite  = 1'b1;
        Out_IDEXWrite  = 1'b1;
        Out_IDEXBubble = 1'b0;
        Out_IFIDFlush  = 1'b0;
        stall          = 1'b0;
        state_d        = RUN;
        rem_d          = rem_q;
        if (state_q == FLUSH) begin
            Out_IDEXBubble = 1'b1;
            Out_IFIDFlush  = 1'b1;
            rem_d          = rem_q - 4'd1;
            state_d        = (rem_q == 4'd1) ? RUN : FLUSH;
        end else if (In_BranchTaken) begin
            Out_IDEXBubble = 1'b1;
            Out_IFIDFlush  = 1'b1;
            rem_d          = 4'(FLUSH_CYCLES - 1);
            state_d        = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (In_ExBusy) begin
            Out_PCWrite   = 1'b0;
            Out_IFIDWrite = 1'b0;
            Out_IDEXWrite = 1'b0;
            state_d       = HOLD;
        end else if (lu) begin
            Out_PCWrite    = 1'b0;
            Out_IFIDWrite  = 1'b0;
            Out_IDEXBubble = 1'b1;
            stall          = 1'b1;
        end
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= RUN;
            rem_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
            flush_cnt_q <= (Out_IFIDFlush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        end
    end
    assign Out_State      = state_q;
    assign Out_StallCount = stall_cnt_q;
    assign Out_FlushCount = flush_cnt_q;
endmodule
